// File: rtl/fifo_in.sv
// fifo_in: packs a stream of 32-bit host words into 128-bit blocks (first word
// in the most-significant position) and queues complete blocks for the AES core.
module fifo_in #(
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          write_en,
  input  logic [31:0]   data_in,
  input  logic          read_en,
  output logic [127:0]  data_out,
  output logic          fifo_empty,
  output logic          fifo_full,
  output logic [CW-1:0] block_count,
  output logic          overrun,
  output logic          underrun
);

  localparam int            PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  // Assembly register: word 0 in [95:64], word 1 in [63:32], word 2 in [31:0]
  logic [95:0]   asm_q, asm_d;
  logic [1:0]    wcnt_q, wcnt_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovr_q, ovr_d;
  logic          und_q, und_d;
  logic [127:0]  slot_q [DEPTH];

  logic          full_s;
  logic          empty_s;
  logic          wr_ok_s;
  logic          rd_ok_s;
  logic          blk_done_s;
  logic [127:0]  blk_s;

  // Circular pointer advance; DEPTH need not be a power of two
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    if (p == LAST_PTR) begin
      return '0;
    end else begin
      return p + PW'(1);
    end
  endfunction

  // Accept/reject decisions and next-state computation from pre-edge state
  always_comb begin
    empty_s    = (count_q == {CW{1'b0}});
    full_s     = (count_q == DEPTH_C) && (wcnt_q == 2'd3);
    wr_ok_s    = write_en && !full_s;
    rd_ok_s    = read_en && !empty_s;
    blk_done_s = wr_ok_s && (wcnt_q == 2'd3);
    blk_s      = {asm_q, data_in};

    asm_d   = asm_q;
    wcnt_d  = wcnt_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    ovr_d   = write_en && full_s;
    und_d   = read_en && empty_s;

    if (wr_ok_s) begin
      case (wcnt_q)
        2'd0:    asm_d[95:64] = data_in;
        2'd1:    asm_d[63:32] = data_in;
        2'd2:    asm_d[31:0]  = data_in;
        default: asm_d        = asm_q;
      endcase
      wcnt_d = wcnt_q + 2'd1;
    end else begin
      wcnt_d = wcnt_q;
    end

    if (blk_done_s) begin
      tail_d = next_ptr(tail_q);
    end else begin
      tail_d = tail_q;
    end

    if (rd_ok_s) begin
      head_d = next_ptr(head_q);
    end else begin
      head_d = head_q;
    end

    case ({blk_done_s, rd_ok_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state and event pulses; reset discards any partial block
  always_ff @(posedge clk) begin
    if (n_rst) begin
      asm_q   <= 96'h0;
      wcnt_q  <= 2'd0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ovr_q   <= 1'b0;
      und_q   <= 1'b0;
    end else begin
      asm_q   <= asm_d;
      wcnt_q  <= wcnt_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ovr_q   <= ovr_d;
      und_q   <= und_d;
    end
  end

  // Block storage; contents survive reset since pointers make them unreachable
  always_ff @(posedge clk) begin
    if (!n_rst && blk_done_s) begin
      slot_q[tail_q] <= blk_s;
    end
  end

  // Output decode from registered state only; partial blocks never shown
  always_comb begin
    if (empty_s) begin
      data_out = 128'h0;
    end else begin
      data_out = slot_q[head_q];
    end
    fifo_empty  = empty_s;
    fifo_full   = full_s;
    block_count = count_q;
    overrun     = ovr_q;
    underrun    = und_q;
  end

endmodule

// File: tb/tb_fifo_in.sv
// Self-checking bench for fifo_in: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_fifo_in;

  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          n_rst = 1'b1;
  logic          write_en = 1'b0;
  logic [31:0]   data_in = 32'h0;
  logic          read_en = 1'b0;
  logic [127:0]  data_out;
  logic          fifo_empty;
  logic          fifo_full;
  logic [CW-1:0] block_count;
  logic          overrun;
  logic          underrun;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: complete blocks and the words of the block in progress
  logic [127:0] mq [$];
  logic [31:0]  pw [$];
  bit           m_ovr;
  bit           m_und;

  fifo_in #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .write_en    (write_en),
    .data_in     (data_in),
    .read_en     (read_en),
    .data_out    (data_out),
    .fifo_empty  (fifo_empty),
    .fifo_full   (fifo_full),
    .block_count (block_count),
    .overrun     (overrun),
    .underrun    (underrun)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] exp_data();
    if (mq.size() > 0) return mq[0];
    else return 128'h0;
  endfunction

  function automatic logic [CW-1:0] exp_count();
    return CW'(mq.size());
  endfunction

  // One clock: drive inputs, advance the model on the edge, settle for sampling
  task automatic cycle(input bit we, input logic [31:0] d, input bit re, input bit rst);
    bit full;
    write_en = we;
    data_in  = d;
    read_en  = re;
    n_rst    = rst;
    @(posedge clk);
    if (rst) begin
      mq.delete();
      pw.delete();
      m_ovr = 1'b0;
      m_und = 1'b0;
    end else begin
      full  = (mq.size() == DEPTH) && (pw.size() == 3);
      m_ovr = we && full;
      m_und = re && (mq.size() == 0);
      if (re && mq.size() > 0) void'(mq.pop_front());
      if (we && !full) begin
        if (pw.size() == 3) begin
          mq.push_back({pw[0], pw[1], pw[2], d});
          pw.delete();
        end else begin
          pw.push_back(d);
        end
      end
    end
    #1;
    write_en = 1'b0;
    read_en  = 1'b0;
    n_rst    = 1'b0;
    data_in  = 32'h0;
  endtask

  task automatic test_reset();
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    n_vec++; if (fifo_empty !== 1'b1) begin n_err++; $display("FAIL reset_empty: got %b want 1", fifo_empty); end
    n_vec++; if (fifo_full !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b want 0", fifo_full); end
    n_vec++; if (block_count !== CW'(0)) begin n_err++; $display("FAIL reset_count: got %0d want 0", block_count); end
    n_vec++; if (data_out !== 128'h0) begin n_err++; $display("FAIL reset_data: got %h want 0", data_out); end
    n_vec++; if (overrun !== 1'b0 || underrun !== 1'b0) begin n_err++; $display("FAIL reset_pulses: got %b%b want 00", overrun, underrun); end
  endtask

  task automatic test_single_block();
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    cycle(1'b1, 32'hAAAAAAAA, 1'b0, 1'b0);
    cycle(1'b1, 32'hBBBBBBBB, 1'b0, 1'b0);
    cycle(1'b1, 32'hCCCCCCCC, 1'b0, 1'b0);
    n_vec++; if (fifo_empty !== 1'b1) begin n_err++; $display("FAIL partial_hidden: empty got %b want 1", fifo_empty); end
    cycle(1'b1, 32'hDDDDDDDD, 1'b0, 1'b0);
    n_vec++; if (data_out !== 128'hAAAAAAAABBBBBBBBCCCCCCCCDDDDDDDD) begin n_err++; $display("FAIL block_order: got %h want AAAAAAAABBBBBBBBCCCCCCCCDDDDDDDD", data_out); end
    n_vec++; if (block_count !== CW'(1)) begin n_err++; $display("FAIL block_count1: got %0d want 1", block_count); end
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    n_vec++; if (fifo_empty !== 1'b1 || data_out !== 128'h0) begin n_err++; $display("FAIL pop_to_empty: empty %b data %h want 1 / 0", fifo_empty, data_out); end
  endtask

  task automatic test_full_overrun();
    logic [31:0] w;
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 11; i++) cycle(1'b1, $urandom, 1'b0, 1'b0);
    n_vec++; if (fifo_full !== 1'b1) begin n_err++; $display("FAIL full_flag: got %b want 1", fifo_full); end
    w = $urandom;
    cycle(1'b1, w, 1'b0, 1'b0);
    n_vec++; if (overrun !== 1'b1) begin n_err++; $display("FAIL overrun_pulse: got %b want 1", overrun); end
    n_vec++; if (block_count !== CW'(2)) begin n_err++; $display("FAIL overrun_count: got %0d want 2", block_count); end
    n_vec++; if (data_out !== exp_data()) begin n_err++; $display("FAIL overrun_head: got %h want %h", data_out, exp_data()); end
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL overrun_one_cycle: got %b want 0", overrun); end
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b1, w, 1'b0, 1'b0);
    n_vec++; if (block_count !== CW'(2)) begin n_err++; $display("FAIL rewrite_count: got %0d want 2", block_count); end
    for (int i = 0; i < 2; i++) begin
      n_vec++; if (data_out !== exp_data()) begin n_err++; $display("FAIL wrap_order%0d: got %h want %h", i, data_out, exp_data()); end
      cycle(1'b0, 32'h0, 1'b1, 1'b0);
    end
    n_vec++; if (fifo_empty !== 1'b1) begin n_err++; $display("FAIL wrap_drained: empty got %b want 1", fifo_empty); end
  endtask

  task automatic test_simul_rw();
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 11; i++) cycle(1'b1, $urandom, 1'b0, 1'b0);
    cycle(1'b1, 32'h12345678, 1'b1, 1'b0);
    n_vec++; if (overrun !== 1'b1) begin n_err++; $display("FAIL simul_overrun: got %b want 1", overrun); end
    n_vec++; if (block_count !== CW'(1)) begin n_err++; $display("FAIL simul_count: got %0d want 1", block_count); end
    cycle(1'b1, 32'h9ABCDEF0, 1'b0, 1'b0);
    n_vec++; if (block_count !== CW'(2) || fifo_full !== 1'b0) begin n_err++; $display("FAIL simul_next: count %0d full %b want 2 / 0", block_count, fifo_full); end
    n_vec++; if (data_out !== exp_data()) begin n_err++; $display("FAIL simul_head: got %h want %h", data_out, exp_data()); end
  endtask

  task automatic test_underrun_midreset();
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    n_vec++; if (underrun !== 1'b1) begin n_err++; $display("FAIL underrun_pulse: got %b want 1", underrun); end
    n_vec++; if (block_count !== CW'(0) || fifo_empty !== 1'b1) begin n_err++; $display("FAIL underrun_state: count %0d empty %b want 0 / 1", block_count, fifo_empty); end
    cycle(1'b1, 32'hDEAD0001, 1'b0, 1'b0);
    cycle(1'b1, 32'hDEAD0002, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    cycle(1'b1, 32'h00000011, 1'b0, 1'b0);
    cycle(1'b1, 32'h00000022, 1'b0, 1'b0);
    cycle(1'b1, 32'h00000033, 1'b0, 1'b0);
    cycle(1'b1, 32'h00000044, 1'b0, 1'b0);
    n_vec++; if (data_out !== 128'h00000011000000220000003300000044) begin n_err++; $display("FAIL midreset_block: got %h want 00000011000000220000003300000044", data_out); end
  endtask

  task automatic test_back_to_back();
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) cycle(1'b1, $urandom, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      n_vec++; if (data_out !== exp_data()) begin n_err++; $display("FAIL b2b_pop%0d: got %h want %h", i, data_out, exp_data()); end
      cycle(1'b0, 32'h0, 1'b1, 1'b0);
    end
    n_vec++; if (fifo_empty !== 1'b1) begin n_err++; $display("FAIL b2b_empty: got %b want 1", fifo_empty); end
  endtask

  task automatic test_random();
    bit we, re, rst;
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 600; i++) begin
      we  = ($urandom_range(0, 99) < 75);
      re  = (i < 300) ? ($urandom_range(0, 99) < 8) : ($urandom_range(0, 99) < 45);
      rst = ($urandom_range(0, 199) == 0);
      cycle(we, $urandom, re, rst);
      n_vec++; if (data_out !== exp_data()) begin n_err++; $display("FAIL rnd_data[%0d]: got %h want %h", i, data_out, exp_data()); end
      n_vec++; if (block_count !== exp_count()) begin n_err++; $display("FAIL rnd_count[%0d]: got %0d want %0d", i, block_count, exp_count()); end
      n_vec++; if (fifo_empty !== (mq.size() == 0)) begin n_err++; $display("FAIL rnd_empty[%0d]: got %b want %b", i, fifo_empty, mq.size() == 0); end
      n_vec++; if (fifo_full !== ((mq.size() == DEPTH) && (pw.size() == 3))) begin n_err++; $display("FAIL rnd_full[%0d]: got %b", i, fifo_full); end
      n_vec++; if (overrun !== m_ovr) begin n_err++; $display("FAIL rnd_overrun[%0d]: got %b want %b", i, overrun, m_ovr); end
      n_vec++; if (underrun !== m_und) begin n_err++; $display("FAIL rnd_underrun[%0d]: got %b want %b", i, underrun, m_und); end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single_block();
    test_full_overrun();
    test_simul_rw();
    test_underrun_midreset();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
